// File: rtl/pwm_timer_pkg.sv
// Shared constants for the buzzer PWM/beep timer.
package pwm_timer_pkg;

  // Timer FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Mode input / shadow encoding
  localparam logic [0:0] MODE_ONESHOT  = 1'b0;
  localparam logic [0:0] MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/clk_en_prescaler.sv
// Clock-enable prescaler: while running, ce pulses once every (prescale+1) clk.
// prescale is used live; the >= compare keeps ce firing if prescale is lowered
// below the current count, so the counter never has to wrap around PRE_W.
module clk_en_prescaler #(
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [PRE_W-1:0] prescale,
  output logic             ce
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  // Enable decode and next prescaler count
  always_comb begin
    ce        = run && (pre_cnt_q >= prescale);
    pre_cnt_d = pre_cnt_q;
    if (clr || ce) begin
      pre_cnt_d = '0;
    end else if (run) begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  // Prescaler count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_beep_timer.sv
// Buzzer timer/PWM generator: prescaled main counter, IDLE/RUN FSM,
// shadow-registered period/duty/mode, registered terminal tick, sticky done.
module pwm_beep_timer
  import pwm_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [PRE_W-1:0] prescale,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  output logic [CNT_W-1:0] cnt_now,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic             pwm_out
);

  logic [0:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q,   duty_d;
  logic             mode_q,   mode_d;
  logic             tick_q,   tick_d;
  logic             done_q,   done_d;
  logic             run;
  logic             ce;

  assign run = (state_q == ST_RUN);

  clk_en_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (start || stop),
    .run      (run),
    .prescale (prescale),
    .ce       (ce)
  );

  // FSM, counter and shadow next-state; stop beats start, start beats ce
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    duty_d   = duty_q;
    mode_d   = mode_q;
    done_d   = done_q;
    tick_d   = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      done_d   = 1'b0;
      period_d = period;
      duty_d   = duty;
      mode_d   = mode;
    end else if (run && ce) begin
      if (cnt_q == period_q) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        if (mode_q == MODE_PERIODIC) begin
          period_d = period;
          duty_d   = duty;
          mode_d   = mode;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      duty_q   <= '0;
      mode_q   <= MODE_ONESHOT;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  // Outputs decode from registers only, so pwm_out cannot glitch
  assign pwm_out = run && (cnt_q < duty_q);
  assign busy    = run;
  assign cnt_now = cnt_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule
